// File: rtl/nv_nvdla_hls_shiftleft_ss_pipe_if.sv
// Handshake/data bundle for nv_nvdla_hls_shiftleft_ss_pipe.
// master = producer/consumer side (drives inputs, takes the output ready),
// slave  = the pipe itself.
interface nv_nvdla_hls_shiftleft_ss_pipe_if #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 49,
  parameter int SHIFT_WIDTH = 6
);
  logic                   in_pvld;
  logic                   in_prdy;
  logic [IN_WIDTH-1:0]    in_data;
  logic [SHIFT_WIDTH-1:0] in_shift;
  logic                   out_pvld;
  logic                   out_prdy;
  logic [OUT_WIDTH-1:0]   out_data;
  logic                   out_sat;

  modport master (
    output in_pvld, in_data, in_shift, out_prdy,
    input  in_prdy, out_pvld, out_data, out_sat
  );

  modport slave (
    input  in_pvld, in_data, in_shift, out_prdy,
    output in_prdy, out_pvld, out_data, out_sat
  );
endinterface

// File: rtl/nv_nvdla_hls_shiftleft_ss_pipe.sv
// Two-stage pipelined signed left shift with saturation to OUT_WIDTH bits.
// Stage 1 holds the shifted/saturated result, stage 2 is the output register.
// Optional saturation counter: define NVDLA_SHL_SAT_CNT_EN to build it;
// otherwise sat_cnt is tied to 0 and sat_cnt_clr is ignored.
//
// Handshake: a transfer happens on a port in any cycle where pvld & prdy.
// pvld never waits on prdy; once raised, out_pvld and its data/sat stay
// stable until out_prdy is seen. in_prdy depends only on pipe state and
// out_prdy (never on in_pvld), so a full pipe that drains this cycle
// still accepts a new operand in the same cycle.
module nv_nvdla_hls_shiftleft_ss_pipe #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 49,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  nv_nvdla_hls_shiftleft_ss_pipe_if.slave bus,
  input  logic        sat_cnt_clr,
  output logic [31:0] sat_cnt
);

  // Wide enough that the largest shift never loses bits before the
  // saturation test looks at them.
  localparam int EXT_W = IN_WIDTH + (1 << SHIFT_WIDTH);
  localparam int TOP_W = EXT_W - OUT_WIDTH + 1;

  localparam logic [OUT_WIDTH-1:0] POS_FS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NEG_FS = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [EXT_W-1:0]     w_ext;
  logic [EXT_W-1:0]     w_full;
  logic [TOP_W-1:0]     w_top;
  logic                 w_sat;
  logic [OUT_WIDTH-1:0] w_res;

  logic                 w_in_xfer;
  logic                 w_s2_ld;
  logic                 w_in_prdy;
  logic                 w_out_xfer;

  logic                 r_s1_vld;
  logic [OUT_WIDTH-1:0] r_s1_data;
  logic                 r_s1_sat;
  logic                 r_s2_vld;
  logic [OUT_WIDTH-1:0] r_s2_data;
  logic                 r_s2_sat;

  // Stage-1 arithmetic: sign-extend, shift, and clamp when the bits above the
  // output sign bit disagree with it (i.e. the value does not fit).
  always_comb begin
    w_ext  = {{(EXT_W-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
    w_full = w_ext << bus.in_shift;
    w_top  = w_full[EXT_W-1:OUT_WIDTH-1];
    w_sat  = !((&w_top) || !(|w_top));
    if (w_sat) begin
      w_res = bus.in_data[IN_WIDTH-1] ? NEG_FS : POS_FS;
    end else begin
      w_res = w_full[OUT_WIDTH-1:0];
    end
  end

  // Handshake decode: stage 2 takes stage 1 whenever the output slot is free
  // or being drained; the input is ready whenever at least one slot frees up.
  always_comb begin
    w_in_prdy  = !r_s1_vld || !r_s2_vld || bus.out_prdy;
    w_in_xfer  = bus.in_pvld && w_in_prdy;
    w_s2_ld    = r_s1_vld && (!r_s2_vld || bus.out_prdy);
    w_out_xfer = r_s2_vld && bus.out_prdy;
  end

  // Stage-1 valid: set on accept, cleared when its entry moves to stage 2.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s1_vld <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_vld <= 1'b1;
    end else if (w_s2_ld) begin
      r_s1_vld <= 1'b0;
    end
  end

  // Stage-1 payload: only loads on an accepted transfer.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s1_data <= '0;
      r_s1_sat  <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_data <= w_res;
      r_s1_sat  <= w_sat;
    end
  end

  // Stage-2 valid: set when stage 1 moves in, cleared when drained empty.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s2_vld <= 1'b0;
    end else if (w_s2_ld) begin
      r_s2_vld <= 1'b1;
    end else if (bus.out_prdy) begin
      r_s2_vld <= 1'b0;
    end
  end

  // Stage-2 payload: loads only on advance, so it is held under back-pressure.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_s2_data <= '0;
      r_s2_sat  <= 1'b0;
    end else if (w_s2_ld) begin
      r_s2_data <= r_s1_data;
      r_s2_sat  <= r_s1_sat;
    end
  end

  assign bus.in_prdy  = w_in_prdy;
  assign bus.out_pvld = r_s2_vld;
  assign bus.out_data = r_s2_data;
  assign bus.out_sat  = r_s2_sat;

`ifdef NVDLA_SHL_SAT_CNT_EN
  logic [31:0] r_sat_cnt;

  // Saturation event counter: clear has priority, sticks at all-ones.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      r_sat_cnt <= '0;
    end else if (w_out_xfer && r_s2_sat && (r_sat_cnt != 32'hFFFF_FFFF)) begin
      r_sat_cnt <= r_sat_cnt + 32'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`else
  logic w_unused_cnt;

  // Counter not built: the clear input and the output-transfer strobe are unused.
  assign w_unused_cnt = sat_cnt_clr ^ w_out_xfer;
  assign sat_cnt      = 32'd0;
`endif

endmodule

// File: tb/tb_nv_nvdla_hls_shiftleft_ss_pipe.sv
// Bench for nv_nvdla_hls_shiftleft_ss_pipe (32 -> 49 bits, 6-bit shift).
// Reference model computes value * 2^shift in 128-bit signed arithmetic and
// clamps against the 49-bit signed range.
module tb_nv_nvdla_hls_shiftleft_ss_pipe;

  localparam int IN_W  = 32;
  localparam int OUT_W = 49;
  localparam int SH_W  = 6;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sat_cnt_clr;
  logic [31:0] sat_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int prdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  logic [OUT_W:0] exp_q[$];  // {sat, data}

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  nv_nvdla_hls_shiftleft_ss_pipe_if #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT_WIDTH(SH_W)
  ) u_if ();

  nv_nvdla_hls_shiftleft_ss_pipe #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT_WIDTH(SH_W)
  ) u_dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (u_if),
    .sat_cnt_clr     (sat_cnt_clr),
    .sat_cnt         (sat_cnt)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d, input logic [SH_W-1:0] sh);
    logic signed [127:0] v;
    logic signed [127:0] p;
    logic signed [127:0] maxv;
    logic signed [127:0] minv;
    v    = {{(128-IN_W){d[IN_W-1]}}, d};
    p    = 128'sd1 <<< sh;
    v    = v * p;
    maxv = (128'sd1 <<< (OUT_W-1)) - 128'sd1;
    minv = -(128'sd1 <<< (OUT_W-1));
    if (v > maxv) return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    if (v < minv) return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // ---------------- output-ready driver ----------------
  initial begin
    u_if.out_prdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (prdy_mode)
        0:       u_if.out_prdy = 1'b0;
        1:       u_if.out_prdy = 1'b1;
        default: u_if.out_prdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [OUT_W:0] e;
    if (rstn === 1'b1) begin
      // Ready drops only when two entries are in flight and the output is stalled.
      chk("in_prdy", 64'(u_if.in_prdy),
          64'(!((exp_q.size() == 2) && !u_if.out_prdy)));
      if (u_if.out_pvld && u_if.out_prdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(u_if.out_data), 64'(e[OUT_W-1:0]));
          chk("out_sat",  64'(u_if.out_sat),  64'(e[OUT_W]));
        end
      end
      if (u_if.in_pvld && u_if.in_prdy) exp_q.push_back(model(u_if.in_data, u_if.in_shift));
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic [SH_W-1:0] sh);
    int   t;
    logic acc;
    t   = 0;
    acc = 1'b0;
    u_if.in_pvld  = 1'b1;
    u_if.in_data  = d;
    u_if.in_shift = sh;
    do begin
      @(negedge clk);
      acc = u_if.in_prdy;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
    u_if.in_pvld  = 1'b0;
    u_if.in_data  = $urandom;
    u_if.in_shift = 6'($urandom_range(0, 63));
  endtask

  task automatic drain();
    int t;
    t = 0;
    prdy_mode = 1;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  logic [IN_W-1:0] dir_d  [12] = '{32'h0000_0003, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001,
                                   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFF0};
  logic [SH_W-1:0] dir_sh [12] = '{6'd4,  6'd17, 6'd18, 6'd17,
                                   6'd49, 6'd48, 6'd63, 6'd63,
                                   6'd63, 6'd0,  6'd0,  6'd45};

  initial begin
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    logic [OUT_W:0]  ea;

    rstn          = 1'b0;
    sat_cnt_clr   = 1'b0;
    u_if.in_pvld  = 1'b0;
    u_if.in_data  = '0;
    u_if.in_shift = '0;
    prdy_mode     = 1;
    wait_cycles(3);

    chk("rst_out_pvld", 64'(u_if.out_pvld), 64'(0));
    chk("rst_out_data", 64'(u_if.out_data), 64'(0));
    chk("rst_out_sat",  64'(u_if.out_sat),  64'(0));
    chk("rst_in_prdy",  64'(u_if.in_prdy),  64'(1));
    chk("rst_sat_cnt",  64'(sat_cnt),       64'(0));

    rstn = 1'b1;
    wait_cycles(2);

    // Latency: accept on one edge, out_pvld up after the following edge.
    u_if.in_pvld  = 1'b1;
    u_if.in_data  = 32'h0000_0003;
    u_if.in_shift = 6'd4;
    wait_cycles(1);
    u_if.in_pvld  = 1'b0;
    chk("lat_cycle1_pvld", 64'(u_if.out_pvld), 64'(0));
    wait_cycles(1);
    chk("lat_cycle2_pvld", 64'(u_if.out_pvld), 64'(1));
    chk("basic_data",      64'(u_if.out_data), 64'h30);
    chk("basic_sat",       64'(u_if.out_sat),  64'(0));
    drain();

    // Directed range edges, checked through the scoreboard.
    for (int i = 0; i < 12; i++) send(dir_d[i], dir_sh[i]);
    drain();

`ifndef NVDLA_SHL_SAT_CNT_EN
    chk("sat_cnt_tied0", 64'(sat_cnt), 64'(0));
`endif

    // Random stream with random back-pressure and input gaps.
    prdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      wait_cycles($urandom_range(0, 2));
      send($urandom, ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 20))
                                                  : 6'($urandom_range(0, 63)));
    end
    drain();

    // Fill the pipe with the output stalled.
    prdy_mode = 0;
    wait_cycles(2);
    a  = $urandom;
    b  = $urandom;
    ea = model(a, 6'd9);
    send(a, 6'd9);
    send(b, 6'd40);
    @(negedge clk);
    chk("full_in_prdy",  64'(u_if.in_prdy),  64'(0));
    chk("full_out_pvld", 64'(u_if.out_pvld), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_data", 64'(u_if.out_data), 64'(ea[OUT_W-1:0]));
      chk("hold_sat",  64'(u_if.out_sat),  64'(ea[OUT_W]));
    end

    // Asynchronous reset while full: everything clears immediately.
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_out_pvld", 64'(u_if.out_pvld), 64'(0));
    chk("midrst_out_data", 64'(u_if.out_data), 64'(0));
    chk("midrst_out_sat",  64'(u_if.out_sat),  64'(0));
    chk("midrst_in_prdy",  64'(u_if.in_prdy),  64'(1));
    exp_q.delete();
    @(negedge clk);
    #1;
    rstn = 1'b1;
    prdy_mode = 1;
    wait_cycles(5);
    chk("post_rst_pvld", 64'(u_if.out_pvld), 64'(0));
    for (int i = 0; i < 6; i++) send($urandom, 6'($urandom_range(0, 30)));
    drain();

`ifdef NVDLA_SHL_SAT_CNT_EN
    rstn = 1'b0;
    wait_cycles(1);
    rstn = 1'b1;
    wait_cycles(1);
    send(32'h7FFF_FFFF, 6'd18);
    send(32'h0000_0005, 6'd2);
    send(32'h8000_0000, 6'd20);
    send(32'hFFFF_FFFF, 6'd48);
    send(32'h0000_0001, 6'd63);
    drain();
    wait_cycles(1);
    chk("sat_cnt_three", 64'(sat_cnt), 64'(3));
    sat_cnt_clr = 1'b1;
    send(32'h0000_0001, 6'd63);
    drain();
    wait_cycles(1);
    sat_cnt_clr = 1'b0;
    wait_cycles(1);
    chk("sat_cnt_clr_wins", 64'(sat_cnt), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
